// File: rtl/rv32_pkg.sv
// Shared RV32 architectural constants used by the register file and its
// forwarding logic.
package rv32_pkg;
    localparam int DATA_W        = 32;
    localparam int NUM_ARCH_REGS = 32;
    localparam int REG_AW        = $clog2(NUM_ARCH_REGS);
endpackage

// File: rtl/rf_bypass_mux.sv
// One read port: selects the stored register value, or the same-cycle
// writeback value when forwarding is enabled, and masks the busy bit.
module rf_bypass_mux
    import rv32_pkg::*;
#(
    parameter int DATA_W = rv32_pkg::DATA_W,
    parameter int AW     = rv32_pkg::REG_AW,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]                  rd_addr,
    input  logic [DATA_W-1:0]              stored_data,
    input  logic                           stored_busy,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]      wr_addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           rd_busy
);

    logic              hit;
    logic [DATA_W-1:0] fwd_data;

    // Ascending scan so the highest-indexed matching port is the one kept.
    always_comb begin
        hit      = 1'b0;
        fwd_data = stored_data;
        if (BYPASS != 0) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_addr[k] == rd_addr) && (rd_addr != '0)) begin
                    hit      = 1'b1;
                    fwd_data = wr_data[k];
                end
            end
        end
        rd_data = (rd_addr == '0) ? '0 : fwd_data;
        rd_busy = stored_busy & ~hit;
    end

endmodule

// File: rtl/rf_scoreboard.sv
// Multi-ported register file with a per-register busy scoreboard for
// WAW/RAW hazard detection and a running count of outstanding writes.
module rf_scoreboard
    import rv32_pkg::*;
#(
    parameter int DATA_W   = rv32_pkg::DATA_W,
    parameter int NUM_REGS = rv32_pkg::NUM_ARCH_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS),
    localparam int CW      = $clog2(NUM_REGS + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_RD-1:0][AW-1:0]      rd_addr_i,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data_o,
    output logic [NUM_RD-1:0]              rd_busy_o,
    input  logic                           issue_valid_i,
    input  logic [AW-1:0]                  issue_rd_i,
    output logic                           issue_ready_o,
    input  logic [NUM_WR-1:0]              wr_en_i,
    input  logic [NUM_WR-1:0][AW-1:0]      wr_addr_i,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data_i,
    input  logic                           flush_i,
    output logic [CW-1:0]                  pending_cnt_o
);

    logic [DATA_W-1:0]   regs_reg  [NUM_REGS];
    logic [DATA_W-1:0]   regs_next [NUM_REGS];
    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] wr_clr;
    logic [NUM_REGS-1:0] set_mask;
    logic [CW-1:0]       cnt_reg;
    logic [CW-1:0]       cnt_next;
    logic [CW-1:0]       dec_cnt;
    logic                inc;
    logic                issue_accept;

    always_comb begin
        regs_next = regs_reg;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en_i[k] && (wr_addr_i[k] != '0)) begin
                regs_next[wr_addr_i[k]] = wr_data_i[k];
            end
        end
        regs_next[0] = '0;
    end

    always_comb begin
        wr_clr = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en_i[k] && (wr_addr_i[k] == AW'(i))) begin
                    wr_clr[i] = 1'b1;
                end
            end
        end
    end

    // A busy destination can still issue if this cycle's writeback frees it.
    assign issue_ready_o = !((issue_rd_i != '0) && busy_reg[issue_rd_i] && !wr_clr[issue_rd_i]);
    assign issue_accept  = issue_valid_i && issue_ready_o && (issue_rd_i != '0);

    always_comb begin
        set_mask = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            set_mask[i] = issue_accept && (issue_rd_i == AW'(i));
        end
    end

    // Set wins over clear, so a bit both set and cleared keeps its count.
    always_comb begin
        busy_next = flush_i ? '0 : ((busy_reg & ~wr_clr) | set_mask);
        busy_next[0] = 1'b0;
        inc     = |(set_mask & ~busy_reg);
        dec_cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            dec_cnt = dec_cnt + CW'(busy_reg[i] & wr_clr[i] & ~set_mask[i]);
        end
        cnt_next = flush_i ? '0 : (cnt_reg + CW'(inc) - dec_cnt);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            regs_reg <= regs_next;
            busy_reg <= busy_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign pending_cnt_o = cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            rf_bypass_mux #(
                .DATA_W (DATA_W),
                .AW     (AW),
                .NUM_WR (NUM_WR),
                .BYPASS (BYPASS)
            ) u_bypass (
                .rd_addr     (rd_addr_i[gi]),
                .stored_data (regs_reg[rd_addr_i[gi]]),
                .stored_busy (busy_reg[rd_addr_i[gi]]),
                .wr_en       (wr_en_i),
                .wr_addr     (wr_addr_i),
                .wr_data     (wr_data_i),
                .rd_data     (rd_data_o[gi]),
                .rd_busy     (rd_busy_o[gi])
            );
        end
    endgenerate

    a_cnt_matches_popcount: assert property (
        @(posedge clk_i) disable iff (!rst_ni) cnt_reg == CW'($countones(busy_reg))
    );

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed test of rf_scoreboard: writes, forwarding, hazards, flush, x0, reset.
module tb_rf_scoreboard;
    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [1:0][4:0]  rd_addr_i;
    logic [1:0][31:0] rd_data_o;
    logic [1:0]       rd_busy_o;
    logic             issue_valid_i;
    logic [4:0]       issue_rd_i;
    logic             issue_ready_o;
    logic [1:0]       wr_en_i;
    logic [1:0][4:0]  wr_addr_i;
    logic [1:0][31:0] wr_data_i;
    logic             flush_i;
    logic [5:0]       pending_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    rf_scoreboard dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
        .rd_busy_o     (rd_busy_o),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .issue_ready_o (issue_ready_o),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .flush_i       (flush_i),
        .pending_cnt_o (pending_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        issue_valid_i = 1'b0;
        issue_rd_i    = '0;
        wr_en_i       = '0;
        wr_addr_i     = '0;
        wr_data_i     = '0;
        flush_i       = 1'b0;
    endtask

    task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
        wr_en_i[port]   = 1'b1;
        wr_addr_i[port] = a;
        wr_data_i[port] = d;
    endtask

    task automatic issue(input logic [4:0] a);
        issue_valid_i = 1'b1;
        issue_rd_i    = a;
    endtask

    initial begin
        rst_ni    = 1'b0;
        rd_addr_i = '0;
        idle();
        #2;
        check("rst_pending", 32'(pending_cnt_o), 0);
        check("rst_ready", 32'(issue_ready_o), 1);
        check("rst_busy", 32'(rd_busy_o), 0);
        check("rst_rdata", rd_data_o[0], 0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Write x5 via port 0, forwarded then stored
        wr(0, 5'd5, 32'hDEADBEEF);
        rd_addr_i[0] = 5'd5;
        #1;
        check("x5_bypass", rd_data_o[0], 32'hDEADBEEF);
        tick(); idle();
        #1;
        check("x5_stored", rd_data_o[0], 32'hDEADBEEF);
        check("x5_busy", 32'(rd_busy_o[0]), 0);

        // Two ports write x7, highest port wins
        wr(0, 5'd7, 32'h11);
        wr(1, 5'd7, 32'h22);
        rd_addr_i[1] = 5'd7;
        #1;
        check("x7_bypass", rd_data_o[1], 32'h22);
        tick(); idle();
        #1;
        check("x7_stored", rd_data_o[1], 32'h22);

        // WAW hazard on x3
        issue(5'd3);
        #1;
        check("x3_ready1", 32'(issue_ready_o), 1);
        tick();
        rd_addr_i[0] = 5'd3;
        #1;
        check("x3_pending", 32'(pending_cnt_o), 1);
        check("x3_ready_waw", 32'(issue_ready_o), 0);
        check("x3_rd_busy", 32'(rd_busy_o[0]), 1);
        wr(0, 5'd3, 32'h33);
        #1;
        check("x3_ready_wb", 32'(issue_ready_o), 1);
        check("x3_busy_fwd", 32'(rd_busy_o[0]), 0);
        check("x3_data_fwd", rd_data_o[0], 32'h33);
        tick(); idle();
        #1;
        check("x3_set_wins", 32'(pending_cnt_o), 1);
        check("x3_still_busy", 32'(rd_busy_o[0]), 1);
        wr(1, 5'd3, 32'h34);
        tick(); idle();
        #1;
        check("x3_cleared", 32'(pending_cnt_o), 0);

        // Issue and writeback x9 together while busy
        issue(5'd9);
        tick(); idle();
        rd_addr_i[1] = 5'd9;
        #1;
        check("x9_pending1", 32'(pending_cnt_o), 1);
        issue(5'd9);
        wr(0, 5'd9, 32'h99);
        tick(); idle();
        #1;
        check("x9_pending_same", 32'(pending_cnt_o), 1);
        check("x9_busy", 32'(rd_busy_o[1]), 1);
        wr(0, 5'd9, 32'h98);
        tick(); idle();
        #1;
        check("x9_cleared", 32'(pending_cnt_o), 0);

        // Three issues then flush overriding issue x6, write still lands
        issue(5'd1); tick();
        issue(5'd2); tick();
        issue(5'd4); tick(); idle();
        #1;
        check("three_pending", 32'(pending_cnt_o), 3);
        flush_i = 1'b1;
        issue(5'd6);
        wr(1, 5'd10, 32'hAB);
        tick(); idle();
        rd_addr_i[0] = 5'd6;
        rd_addr_i[1] = 5'd1;
        #1;
        check("flush_pending", 32'(pending_cnt_o), 0);
        check("flush_busy", 32'(rd_busy_o), 0);
        rd_addr_i[0] = 5'd10;
        #1;
        check("flush_write", rd_data_o[0], 32'hAB);

        // x0 never written nor busy
        wr(1, 5'd0, 32'hFFFFFFFF);
        issue(5'd0);
        rd_addr_i[0] = 5'd0;
        #1;
        check("x0_ready", 32'(issue_ready_o), 1);
        check("x0_bypass", rd_data_o[0], 0);
        tick(); idle();
        #1;
        check("x0_read", rd_data_o[0], 0);
        check("x0_busy", 32'(rd_busy_o[0]), 0);
        check("x0_pending", 32'(pending_cnt_o), 0);

        // Mid-operation asynchronous reset
        issue(5'd2); tick();
        rd_addr_i[0] = 5'd5;
        rd_addr_i[1] = 5'd2;
        #1;
        check("pre_rst_pending", 32'(pending_cnt_o), 1);
        check("pre_rst_ready", 32'(issue_ready_o), 0);
        #1;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_pending", 32'(pending_cnt_o), 0);
        check("mid_rst_ready", 32'(issue_ready_o), 1);
        check("mid_rst_busy", 32'(rd_busy_o), 0);
        check("mid_rst_x5", rd_data_o[0], 0);
        idle();
        tick();
        rst_ni = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
